// File: rtl/phivers_inj_arb.sv
// phivers_inj_arb: round-robin merge of N_CH Hermes injector channels onto one boundary port
// Optional watchdog compiled in by defining PHIVERS_INJ_WATCHDOG_EN.
// Ports:
//   clk_i     - clock, all state on rising edge
//   rst_ni    - asynchronous active-low reset
//   rx_i      - per-channel flit valid
//   data_i    - per-channel flits, channel c at [c*FLIT_SIZE +: FLIT_SIZE]
//   credit_o  - per-channel accept (only the granted channel, only when output register is free)
//   tx_o      - registered boundary flit valid
//   data_o    - registered boundary flit
//   credit_i  - boundary accept
//   grant_o   - index of the channel owning the boundary port
//   stall_o   - sticky watchdog flag (0 when the watchdog is not built)
module phivers_inj_arb #(
    parameter int N_CH       = 2,
    parameter int FLIT_SIZE  = 32,
    parameter int WDT_CYCLES = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_CH-1:0]              rx_i,
    input  logic [N_CH*FLIT_SIZE-1:0]    data_i,
    output logic [N_CH-1:0]              credit_o,
    output logic                         tx_o,
    output logic [FLIT_SIZE-1:0]         data_o,
    input  logic                         credit_i,
    output logic [$clog2(N_CH)-1:0]      grant_o,
    output logic                         stall_o
);
    localparam int GW = $clog2(N_CH);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_SIZE, S_PAYLOAD} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [GW-1:0]        r_grant;
    logic [GW-1:0]        r_rr;
    logic [GW-1:0]        w_sel;
    logic [GW-1:0]        w_nxt_rr;
    logic [FLIT_SIZE-1:0] r_cnt;
    logic [FLIT_SIZE-1:0] r_data;
    logic [FLIT_SIZE-1:0] w_flit;
    logic                 r_tx;
    logic                 w_free;
    logic                 w_act;
    logic                 w_acc;
    logic                 w_last;

    assign w_flit   = data_i[int'(r_grant)*FLIT_SIZE +: FLIT_SIZE];
    assign w_free   = !r_tx || credit_i;
    assign w_act    = r_state != S_IDLE;
    assign w_acc    = w_act && w_free && rx_i[r_grant];
    assign w_last   = (r_state == S_SIZE && w_flit == '0) || (r_state == S_PAYLOAD && r_cnt == FLIT_SIZE'(1));
    assign w_nxt_rr = (r_grant == GW'(N_CH - 1)) ? '0 : r_grant + 1'b1;

    // Scan from the highest offset down so the closest requester at or after r_rr wins.
    always_comb begin
        w_sel = r_rr;
        for (int i = N_CH - 1; i >= 0; i--)
            if (rx_i[(int'(r_rr) + i) % N_CH]) w_sel = GW'((int'(r_rr) + i) % N_CH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == S_IDLE) ? (|rx_i ? S_HEADER : S_IDLE) :
                 !w_acc              ? r_state :
                 (r_state == S_HEADER) ? S_SIZE :
                 w_last              ? S_IDLE : S_PAYLOAD;
    end

    always_comb begin
        credit_o          = '0;
        credit_o[r_grant] = w_act && w_free;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant <= '0;
            r_rr    <= '0;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_data  <= '0;
        end else begin
            if (r_state == S_IDLE && |rx_i) r_grant <= w_sel;
            if (w_acc && w_last) r_rr <= w_nxt_rr;
            if (w_acc && r_state == S_SIZE) r_cnt <= w_flit;
            else if (w_acc && r_state == S_PAYLOAD) r_cnt <= r_cnt - 1'b1;
            // A pending flit drains while the next one loads, so acceptance always wins.
            if (w_acc) begin
                r_tx   <= 1'b1;
                r_data <= w_flit;
            end else if (credit_i) begin
                r_tx <= 1'b0;
            end
        end
    end

    assign tx_o    = r_tx;
    assign data_o  = r_data;
    assign grant_o = r_grant;

`ifdef PHIVERS_INJ_WATCHDOG_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);

    logic [WW-1:0] r_wdt;
    logic          r_stall;
    logic          w_silent;

    // Any cycle the owner is not silent (including every accepted flit) restarts the count.
    assign w_silent = (r_state == S_SIZE || r_state == S_PAYLOAD) && !rx_i[r_grant];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdt   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_wdt <= !w_silent ? '0 : (r_wdt == WW'(WDT_CYCLES)) ? r_wdt : r_wdt + 1'b1;
            if (w_silent && r_wdt == WW'(WDT_CYCLES - 1)) r_stall <= 1'b1;
        end
    end

    assign stall_o = r_stall;
`else
    // Constant 0; WDT_CYCLES has no effect in this build.
    assign stall_o = (WDT_CYCLES < 0);
`endif
endmodule

// File: tb/tb_phivers_inj_arb.sv
// tb_phivers_inj_arb: directed self-checking bench for phivers_inj_arb (N_CH=2, FLIT_SIZE=32, WDT_CYCLES=8)
module tb_phivers_inj_arb;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  rx_i;
    logic [63:0] data_i;
    logic [1:0]  credit_o;
    logic        tx_o;
    logic [31:0] data_o;
    logic        credit_i;
    logic [0:0]  grant_o;
    logic        stall_o;
    int          checks = 0;
    int          errors = 0;

    phivers_inj_arb #(.N_CH(2), .FLIT_SIZE(32), .WDT_CYCLES(8)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rx_i     (rx_i),
        .data_i   (data_i),
        .credit_o (credit_o),
        .tx_o     (tx_o),
        .data_o   (data_o),
        .credit_i (credit_i),
        .grant_o  (grant_o),
        .stall_o  (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d);
        chk(tag, {tx_o, data_o}, {1'b1, d});
    endtask

    task automatic setd(input int ch, input logic [31:0] v);
        data_i[ch*32 +: 32] = v;
    endtask

    initial begin
        rst_ni = 1'b0; rx_i = '0; data_i = '0; credit_i = 1'b1;
        #12;
        chk("rst_tx", 33'(tx_o), 33'd0);
        chk("rst_data", 33'(data_o), 33'd0);
        chk("rst_credit", 33'(credit_o), 33'd0);
        chk("rst_grant", 33'(grant_o), 33'd0);
        chk("rst_stall", 33'(stall_o), 33'd0);
        @(negedge clk_i) rst_ni = 1'b1;

        // Single packet, continuous credit
        rx_i = 2'b01; setd(0, 32'h0101);
        cyc; chk("t1_grant", 33'(grant_o), 33'd0); chk("t1_credit", 33'(credit_o), 33'd1); chk("t1_tx0", 33'(tx_o), 33'd0);
        cyc; chk_out("t1_hdr", 32'h0101); setd(0, 32'd3);
        cyc; chk_out("t1_size", 32'd3); setd(0, 32'hA);
        cyc; chk_out("t1_a", 32'hA); setd(0, 32'hB);
        cyc; chk_out("t1_b", 32'hB); setd(0, 32'hC);
        cyc; chk_out("t1_c", 32'hC); rx_i = 2'b00; chk("t1_idle_credit", 33'(credit_o), 33'd0);
        cyc; chk("t1_tx_end", 33'(tx_o), 33'd0);

        // Simultaneous requests after reset: ch0, then ch1, then ch0 again
        rst_ni = 1'b0; #2; rst_ni = 1'b1;
        rx_i = 2'b11; setd(0, 32'h1000); setd(1, 32'h2000);
        cyc; chk("t2_grant0", 33'(grant_o), 33'd0); chk("t2_credit0", 33'(credit_o), 33'd1);
        cyc; chk_out("t2_h0", 32'h1000); setd(0, 32'd1);
        cyc; chk_out("t2_s0", 32'd1); setd(0, 32'h1001);
        cyc; chk_out("t2_p0", 32'h1001); setd(0, 32'h3000); chk("t2_idle_credit", 33'(credit_o), 33'd0);
        cyc; chk("t2_grant1", 33'(grant_o), 33'd1); chk("t2_gap_tx", 33'(tx_o), 33'd0); chk("t2_credit1", 33'(credit_o), 33'd2);
        cyc; chk_out("t2_h1", 32'h2000); setd(1, 32'd1);
        cyc; chk_out("t2_s1", 32'd1); setd(1, 32'h2001);
        cyc; chk_out("t2_p1", 32'h2001); rx_i = 2'b01;
        cyc; chk("t2_grant0b", 33'(grant_o), 33'd0); chk("t2_gap2_tx", 33'(tx_o), 33'd0);
        cyc; chk_out("t2_h2", 32'h3000); setd(0, 32'd0);
        cyc; chk_out("t2_s2", 32'd0); rx_i = 2'b00;
        cyc; chk("t2_tx_end", 33'(tx_o), 33'd0);

        // Boundary stall of 4 cycles mid-payload
        rx_i = 2'b01; setd(0, 32'h4000);
        cyc;
        cyc; chk_out("t3_hdr", 32'h4000); setd(0, 32'd3);
        cyc; chk_out("t3_size", 32'd3); setd(0, 32'h4001);
        cyc; chk_out("t3_p1", 32'h4001); setd(0, 32'h4002); credit_i = 1'b0;
        #1 chk("t3_credit_blk", 33'(credit_o), 33'd0);
        repeat (4) begin
            cyc; chk_out("t3_hold", 32'h4001); chk("t3_hold_credit", 33'(credit_o), 33'd0);
        end
        credit_i = 1'b1;
        #1 chk("t3_credit_rel", 33'(credit_o), 33'd1);
        cyc; chk_out("t3_p2", 32'h4002); setd(0, 32'h4003);
        cyc; chk_out("t3_p3", 32'h4003); rx_i = 2'b00;
        cyc; chk("t3_tx_end", 33'(tx_o), 33'd0);

        // Size-0 packet on ch1, then rr_ptr must point back at ch0
        rx_i = 2'b10; setd(1, 32'h5000);
        cyc; chk("t4_grant1", 33'(grant_o), 33'd1);
        cyc; chk_out("t4_hdr", 32'h5000); setd(1, 32'd0);
        cyc; chk_out("t4_size0", 32'd0); chk("t4_idle_credit", 33'(credit_o), 33'd0);
        rx_i = 2'b11; setd(0, 32'h6000);
        cyc; chk("t4_rr0", 33'(grant_o), 33'd0); chk("t4_tx_end", 33'(tx_o), 33'd0);

        // Asynchronous reset mid-payload, then a fresh packet
        rx_i = 2'b01;
        cyc; chk_out("t5_hdr", 32'h6000); setd(0, 32'd2);
        cyc; chk_out("t5_size", 32'd2); setd(0, 32'h6001);
        cyc; chk_out("t5_p1", 32'h6001); setd(0, 32'h6002);
        #1 rst_ni = 1'b0;
        #1 chk("t5_rst_tx", 33'(tx_o), 33'd0); chk("t5_rst_credit", 33'(credit_o), 33'd0);
        chk("t5_rst_data", 33'(data_o), 33'd0); chk("t5_rst_grant", 33'(grant_o), 33'd0);
        #1 rst_ni = 1'b1; setd(0, 32'h7000);
        cyc; chk("t5_grant", 33'(grant_o), 33'd0);
        cyc; chk_out("t5_fh", 32'h7000); setd(0, 32'd1);
        cyc; chk_out("t5_fs", 32'd1); setd(0, 32'h7001);
        cyc; chk_out("t5_fp", 32'h7001); rx_i = 2'b00;
        cyc; chk("t5_tx_end", 33'(tx_o), 33'd0);

`ifdef PHIVERS_INJ_WATCHDOG_EN
        // Owner goes silent after its size flit
        rx_i = 2'b01; setd(0, 32'h8000);
        cyc;
        cyc; chk_out("t6_hdr", 32'h8000); setd(0, 32'd2);
        cyc; chk_out("t6_size", 32'd2); rx_i = 2'b00;
        repeat (7) cyc;
        chk("t6_stall_7", 33'(stall_o), 33'd0);
        cyc; chk("t6_stall_8", 33'(stall_o), 33'd1);
        rx_i = 2'b01; setd(0, 32'h8001);
        cyc; chk_out("t6_p1", 32'h8001); setd(0, 32'h8002);
        cyc; chk_out("t6_p2", 32'h8002); rx_i = 2'b00;
        cyc; chk("t6_stall_sticky", 33'(stall_o), 33'd1); chk("t6_tx_end", 33'(tx_o), 33'd0);
`else
        chk("stall_tied", 33'(stall_o), 33'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
